keynsham_dp_ram: RTL

Parametrised dual-port on-chip RAM for the Keynsham SoC: one read-only instruction-fetch port and one read/write data port with byte enables, both fully pipelined with explicit acks. Depth and read latency (1 or 2 cycles) are configurable. Same-word data-write/instruction-read collisions resolve write-first, and the data port's read bus is zero when not acking so it can be OR-merged on the data bus. Sits behind the core's instruction and data buses as boot/scratch memory.

---
 rtl/keynsham_ram_pkg.sv | 40 ++++
 rtl/keynsham_ram_pipe.sv | 61 ++++++
 rtl/keynsham_dp_ram.sv | 112 +++++++++++
 3 files changed

// File: rtl/keynsham_ram_pkg.sv
// Shared helpers for the Keynsham dual-port RAM: address decode, byte-lane
// merge and the set of supported read latencies.
package keynsham_ram_pkg;

    // Supported request-to-ack latencies (in clock cycles).
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 2;

    // Number of byte lanes in one memory word.
    localparam int LANES = 4;

    // True when the requested latency can be built by this RAM.
    function automatic bit latency_legal(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    // Word index from a byte address: drop the byte offset, keep addr_bits
    // bits. Upper address bits are ignored so the memory aliases across the
    // whole address window.
    function automatic logic [29:0] word_index(input logic [31:0] addr,
                                               input int          addr_bits);
        return 30'((addr >> 2) & ((32'd1 << addr_bits) - 32'd1));
    endfunction

    // Merge a new word into an old one: lanes with their select bit set take
    // the new byte, every other lane keeps the old byte.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < LANES; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/keynsham_ram_pipe.sv
// Response pipeline for one RAM port: STAGES registered valid/data stages.
// Valid bits are cleared asynchronously by rst so in-flight responses vanish
// at once. With ZERO_INVALID set, a stage holds zero data whenever it is not
// valid (for OR-merged buses); otherwise it keeps the last valid word.
module keynsham_ram_pipe #(
    parameter int STAGES       = 1,
    parameter int W            = 32,
    parameter bit ZERO_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic         up_v;
        logic [W-1:0] up_d;
        logic         vld_d;
        logic         vld_q;
        logic [W-1:0] dat_d;
        logic [W-1:0] dat_q;

        // Stage 0 is fed by the port; later stages by the stage before.
        if (s == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = g_stage[s-1].vld_q;
            assign up_d = g_stage[s-1].dat_q;
        end

        // Next stage contents: load on valid, otherwise zero or hold.
        always_comb begin
            vld_d = up_v;
            dat_d = dat_q;
            if (up_v) begin
                dat_d = up_d;
            end else if (ZERO_INVALID) begin
                dat_d = '0;
            end
        end

        // Stage registers with asynchronous clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign out_data  = g_stage[STAGES-1].dat_q;

endmodule

// File: rtl/keynsham_dp_ram.sv
// Keynsham dual-port RAM: a read-only instruction fetch port and a
// read/write data port with byte enables, sharing one word array.
//
// Handshake: a port issues at most one request per cycle by holding its
// request strobe high for that cycle (i_access, or d_access && d_cs). There is
// no back-pressure: every accepted request is answered by exactly one ack
// pulse LATENCY cycles later, in request order, with the response data valid
// while the ack is high. Requests seen while rst is high are never accepted.
module keynsham_dp_ram
    import keynsham_ram_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch port
    input  logic        i_access,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    // data port
    input  logic        d_access,
    input  logic        d_cs,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    input  logic        d_wr_en,
    output logic [31:0] d_data,
    output logic        d_ack
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    if (!latency_legal(LATENCY)) begin : g_bad_latency
        $error("keynsham_dp_ram: LATENCY must be 1 or 2");
    end

    // Word storage; contents are undefined at power-up and untouched by rst.
    logic [31:0] mem [0:DEPTH-1];

    logic [ADDR_BITS-1:0] i_idx;
    logic [ADDR_BITS-1:0] d_idx;
    logic                 i_accept;
    logic                 d_accept;
    logic                 d_wr_accept;
    logic [31:0]          i_old;
    logic [31:0]          d_old;
    logic [31:0]          d_merged;
    logic [31:0]          i_word;
    logic [31:0]          d_word;

    // Request decode, write merge and write-first fetch forwarding.
    always_comb begin
        i_idx       = ADDR_BITS'(word_index(i_addr, ADDR_BITS));
        d_idx       = ADDR_BITS'(word_index(d_addr, ADDR_BITS));
        i_accept    = i_access && !rst;
        d_accept    = d_access && d_cs && !rst;
        d_wr_accept = d_accept && d_wr_en;
        i_old       = mem[i_idx];
        d_old       = mem[d_idx];
        d_merged    = merge_lanes(d_old, d_wr_val, d_bytesel);
        // A fetch of the word being written this cycle sees the new bytes.
        if (d_wr_accept && (d_idx == i_idx)) begin
            i_word = d_merged;
        end else begin
            i_word = i_old;
        end
        // Write acks carry zero data so the bus can be OR-merged.
        if (d_wr_en) begin
            d_word = '0;
        end else begin
            d_word = d_old;
        end
    end

    // Byte-lane write into the array at the accepting edge.
    always_ff @(posedge clk) begin
        if (d_wr_accept) begin
            mem[d_idx] <= d_merged;
        end
    end

    // Fetch responses hold the last fetched word between acks.
    keynsham_ram_pipe #(
        .STAGES       (LATENCY),
        .W            (32),
        .ZERO_INVALID (1'b0)
    ) u_i_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (i_accept),
        .in_data   (i_word),
        .out_valid (i_ack),
        .out_data  (i_data)
    );

    // Data responses read as zero whenever no ack is presented.
    keynsham_ram_pipe #(
        .STAGES       (LATENCY),
        .W            (32),
        .ZERO_INVALID (1'b1)
    ) u_d_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_accept),
        .in_data   (d_word),
        .out_valid (d_ack),
        .out_data  (d_data)
    );

endmodule
